seq_pattern_monitor: RTL and testbench

//  Downstream consumer of the `sequential` block's 1-bit `out` stream.
//  - Samples the stream serially and detects a fixed PAT_LEN-bit pattern (MSB first).
//  - Emits a one-cycle match pulse per detection.
//  - Keeps a saturating match counter for bench and self-check use.

---
 rtl/seq_pattern_monitor.sv | 120 ++++++++++++
 tb/tb_seq_pattern_monitor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_monitor.sv
// seq_pattern_monitor: serial pattern detector for a 1-bit upstream stream.
// Shifts qualified bits in MSB-first and compares them against PATTERN.
// It raises a one-cycle registered match pulse and keeps a saturating match counter.
// Build option SEQ_MON_OVERLAP_EN: when defined, detection is overlapping.
// When undefined (default), each match restarts the fill from zero.
module seq_pattern_monitor #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             busy
);

  localparam int unsigned        FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FULL   = FILL_W'(PAT_LEN);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HUNT
  } state_t;

  state_t             state, state_n;
  logic [PAT_LEN-1:0] shreg, shreg_n;
  logic [PAT_LEN-1:0] shifted;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [FILL_W-1:0]  fill_inc;
  logic               accept;
  logic               hit;
  logic               match_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               sat_n;

  // Next-state, shift register, fill count and compare for the accepting edge
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    fill_n   = fill;
    match_n  = 1'b0;
    hit      = 1'b0;
    accept   = en && din_valid && (state != IDLE);
    shifted  = {shreg[PAT_LEN-2:0], din};
    // In HUNT the window is already full, so the fill count stays at PAT_LEN
    fill_inc = (state == HUNT) ? FULL : fill + 1'b1;

    if (!en) begin
      state_n = IDLE;
      shreg_n = '0;
      fill_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = FILL;
        FILL, HUNT: begin
          if (accept) begin
            shreg_n = shifted;
            fill_n  = fill_inc;
            if (fill_inc == FULL) begin
              state_n = HUNT;
              hit     = (shifted == PATTERN);
            end
            if (hit) begin
              match_n = 1'b1;
`ifdef SEQ_MON_OVERLAP_EN
              state_n = HUNT;
`else
              state_n = FILL;
              shreg_n = '0;
              fill_n  = '0;
`endif
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Saturating counter: clear takes effect first, so a coincident match lands on a zeroed count
  always_comb begin
    cnt_n = clr_cnt ? '0 : match_cnt;
    sat_n = clr_cnt ? 1'b0 : cnt_sat;
    if (match_n && !sat_n) begin
      cnt_n = cnt_n + 1'b1;
      if (cnt_n == '1) begin
        sat_n = 1'b1;
      end
    end
  end

  // State and output registers; synchronous reset has priority over everything
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      shreg     <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      fill      <= fill_n;
      match     <= match_n;
      match_cnt <= cnt_n;
      cnt_sat   <= sat_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_seq_pattern_monitor.sv
// tb_seq_pattern_monitor: directed and random stimulus for seq_pattern_monitor.
// Two instances share the stimulus: dut_a uses default parameters and dut_b uses CNT_W=2.
// SEQ_MON_OVERLAP_EN selects overlapping detection in both the DUT and the reference.
module tb_seq_pattern_monitor;

  localparam int unsigned PAT_LEN = 4;
  localparam logic [3:0]  PATTERN = 4'b1011;
  localparam int          MAX_A   = 255;
  localparam int          MAX_B   = 3;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       match_a, cnt_sat_a, busy_a;
  logic [7:0] cnt_a;
  logic       match_b, cnt_sat_b, busy_b;
  logic [1:0] cnt_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: enable status, accepted-bit history, matches since last clear
  bit          m_active = 1'b0;
  int          m_nbits  = 0;
  int unsigned m_hist   = 0;
  bit          m_match  = 1'b0;
  int          m_since  = 0;

  seq_pattern_monitor #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .res(res), .en(en), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .match(match_a), .match_cnt(cnt_a), .cnt_sat(cnt_sat_a), .busy(busy_a)
  );

  seq_pattern_monitor #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
    .clk(clk), .res(res), .en(en), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .match(match_b), .match_cnt(cnt_b), .cnt_sat(cnt_sat_b), .busy(busy_b)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_of(input int m, input int mx);
    return (m > mx) ? mx : m;
  endfunction

  // Apply one cycle of inputs, advance the reference across the edge, then compare
  task automatic cyc(input bit r, input bit e, input bit v, input bit d, input bit c);
    res = r; en = e; din_valid = v; din = d; clr_cnt = c;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0; m_nbits = 0; m_hist = 0; m_match = 1'b0; m_since = 0;
    end else begin
      m_match = 1'b0;
      if (!e) begin
        m_active = 1'b0; m_nbits = 0; m_hist = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
      end else if (v) begin
        m_hist  = (m_hist << 1) | int'(d);
        m_nbits = (m_nbits >= int'(PAT_LEN)) ? int'(PAT_LEN) : m_nbits + 1;
        if (m_nbits == int'(PAT_LEN) && (m_hist & 32'hF) == {28'd0, PATTERN}) begin
          m_match = 1'b1;
`ifndef SEQ_MON_OVERLAP_EN
          m_nbits = 0;
          m_hist  = 0;
`endif
        end
      end
      if (c) m_since = int'(m_match);
      else if (m_since < 1000) m_since = m_since + int'(m_match);
    end
    #1;
    check("match_a", {31'd0, match_a}, {31'd0, m_match});
    check("match_b", {31'd0, match_b}, {31'd0, m_match});
    check("busy_a", {31'd0, busy_a}, {31'd0, m_active});
    check("busy_b", {31'd0, busy_b}, {31'd0, m_active});
    check("cnt_a", {24'd0, cnt_a}, 32'(sat_of(m_since, MAX_A)));
    check("sat_a", {31'd0, cnt_sat_a}, {31'd0, m_since >= MAX_A});
    check("cnt_b", {30'd0, cnt_b}, 32'(sat_of(m_since, MAX_B)));
    check("sat_b", {31'd0, cnt_sat_b}, {31'd0, m_since >= MAX_B});
  endtask

  task automatic bits4(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) cyc(0, 1, 1, b[i], 0);
  endtask

  initial begin
    // 1: reset with en held high, then enable takes effect one edge later
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("t1_busy_rst", {31'd0, busy_a}, 32'd0);
    check("t1_cnt_rst", {24'd0, cnt_a}, 32'd0);
    cyc(0, 1, 0, 0, 0);
    check("t1_busy_on", {31'd0, busy_a}, 32'd1);

    // 2: single pattern
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    check("t2_nomatch_early", {31'd0, match_a}, 32'd0);
    cyc(0, 1, 1, 1, 0);
    check("t2_match", {31'd0, match_a}, 32'd1);
    check("t2_cnt", {24'd0, cnt_a}, 32'd1);
    cyc(0, 1, 0, 0, 0);
    check("t2_pulse_end", {31'd0, match_a}, 32'd0);

    // 3: overlap behaviour on 1011011 from a clean window and zero count
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    bits4(4'b1011);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
`ifdef SEQ_MON_OVERLAP_EN
    check("t3_cnt", {24'd0, cnt_a}, 32'd2);
`else
    check("t3_cnt", {24'd0, cnt_a}, 32'd1);
`endif

    // 4: valid gaps do not break the pattern
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    check("t4_cnt", {24'd0, cnt_a}, 32'd1);

    // 5: reset mid-pattern discards the partial bits
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    check("t5_no_stale", {31'd0, match_a}, 32'd0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    check("t5_cnt", {24'd0, cnt_a}, 32'd1);

    // 6: 2-bit counter saturates, then clear coincides with a fifth match
    cyc(0, 1, 0, 0, 1);
    for (int k = 0; k < 4; k++) bits4(4'b1011);
    check("t6_cnt_b_sat", {30'd0, cnt_b}, 32'd3);
    check("t6_sat_b", {31'd0, cnt_sat_b}, 32'd1);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 1);
    check("t6_clr_match", {31'd0, match_b}, 32'd1);
    check("t6_clr_cnt_b", {30'd0, cnt_b}, 32'd1);
    check("t6_clr_sat_b", {31'd0, cnt_sat_b}, 32'd0);

    // Random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 19) != 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom),
          ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
